// File: rtl/violation_reset_ctrl_pkg.sv
// Shared types and constants for the violation reset controller: FSM encoding,
// register word offsets, CAUSE bit positions, violation indices and small helpers.
package violation_reset_ctrl_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ASSERT = 1'b1
    } vrc_state_e;

    // Word offsets inside the four-word register window
    localparam logic [1:0] REG_CAUSE     = 2'd0;
    localparam logic [1:0] REG_COUNT     = 2'd1;
    localparam logic [1:0] REG_LAST_PC   = 2'd2;
    localparam logic [1:0] REG_LAST_ADDR = 2'd3;

    localparam int CAUSE_ILLEGAL_BIT     = 4;
    localparam int CAUSE_FIRST_IDX_LSB   = 8;
    localparam int CAUSE_FIRST_VALID_BIT = 15;

    localparam int VIOL_UART = 0;
    localparam int VIOL_INTR = 1;
    localparam int VIOL_IRQ  = 2;
    localparam int VIOL_GIE  = 3;
    localparam int NUM_VIOL  = 4;

    localparam logic [15:0] COUNT_MAX = 16'hFFFF;

    // Computed in 17 bits so a region ending exactly at 0x10000 still works
    function automatic logic in_region(input logic [15:0] addr,
                                       input logic [15:0] base,
                                       input logic [15:0] size);
        logic [16:0] end_addr;
        end_addr = {1'b0, base} + {1'b0, size};
        return (addr >= base) && ({1'b0, addr} < end_addr);
    endfunction

    function automatic logic [1:0] lowest_idx(input logic [NUM_VIOL-1:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NUM_VIOL - 1; i >= 0; i--) begin
            if (v[i]) idx = i[1:0];
        end
        return idx;
    endfunction

endpackage

// File: rtl/violation_reset_ctrl_if.sv
// openMSP430-style peripheral bus as seen by the violation reset controller.
interface violation_reset_ctrl_if;
    logic [13:0] per_addr;
    logic [15:0] per_din;
    logic        per_en;
    logic [1:0]  per_we;
    logic [15:0] per_dout;

    modport master (output per_addr, per_din, per_en, per_we, input per_dout);
    modport slave  (input per_addr, per_din, per_en, per_we, output per_dout);
endinterface

// File: rtl/violation_reset_ctrl_regs.sv
// Peripheral register window: address decode, TCB write check, W1C cause log,
// event counter and read mux. Optional capture registers under VRC_CAPTURE_EN.
module violation_reset_ctrl_regs
    import violation_reset_ctrl_pkg::*;
#(
    parameter logic [15:0] PER_BASE = 16'h0190,
    parameter logic [15:0] TCB_BASE = 16'hA000,
    parameter logic [15:0] TCB_SIZE = 16'h4000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_VIOL-1:0] ev,
    input  logic                episode_start,
    input  logic [15:0]         pc,
    input  logic [15:0]         data_addr,
    violation_reset_ctrl_if.slave bus
);

    // per_addr is a word address, so the 8-byte window matches on byte bits [15:3]
    localparam logic [11:0] BASE_WORD = PER_BASE[15:3];

    logic        sel, rd, wr, from_tcb, wr_ok, wr_bad;
    logic [1:0]  reg_idx;
    logic        cause_wr, count_wr;
    logic [4:0]  lo_clr;
    logic        first_clr, first_set;

    logic [3:0]  cause_q, cause_d;
    logic        illegal_q, illegal_d;
    logic        first_valid_q, first_valid_d;
    logic [1:0]  first_idx_q, first_idx_d;
    logic [15:0] count_q, count_d;
    logic [15:0] count_base;
    logic [15:0] last_pc_rd, last_addr_rd;
    logic [15:0] rdata;
    logic        unused_din;

    assign sel      = bus.per_en && (bus.per_addr[13:2] == BASE_WORD);
    assign reg_idx  = bus.per_addr[1:0];
    assign rd       = sel && (bus.per_we == 2'b00);
    assign wr       = sel && (bus.per_we != 2'b00);
    assign from_tcb = in_region(pc, TCB_BASE, TCB_SIZE);
    assign wr_ok    = wr && from_tcb;
    assign wr_bad   = wr && !from_tcb;
    assign cause_wr = wr_ok && (reg_idx == REG_CAUSE);
    assign count_wr = wr_ok && (reg_idx == REG_COUNT);

    assign unused_din = ^bus.per_din[14:5];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_count_lane
            assign count_base[gi*8 +: 8] = (count_wr && bus.per_we[gi]) ? 8'h00
                                                                        : count_q[gi*8 +: 8];
        end
    endgenerate

    always_comb begin
        lo_clr        = (cause_wr && bus.per_we[0]) ? bus.per_din[4:0] : 5'b0;
        first_clr     = cause_wr && bus.per_we[1] && bus.per_din[CAUSE_FIRST_VALID_BIT];
        // A new episode may record first even when software clears it in the same cycle
        first_set     = episode_start && (!first_valid_q || first_clr);

        cause_d       = (cause_q & ~lo_clr[3:0]) | ev;
        illegal_d     = (illegal_q & ~lo_clr[CAUSE_ILLEGAL_BIT]) | wr_bad;
        first_valid_d = first_valid_q;
        first_idx_d   = first_idx_q;
        if (first_set) begin
            first_valid_d = 1'b1;
            first_idx_d   = lowest_idx(ev);
        end else if (first_clr) begin
            first_valid_d = 1'b0;
            first_idx_d   = 2'd0;
        end

        count_d = count_base;
        if ((|ev) && (count_base != COUNT_MAX)) count_d = count_base + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cause_q       <= '0;
            illegal_q     <= 1'b0;
            first_valid_q <= 1'b0;
            first_idx_q   <= '0;
            count_q       <= '0;
        end else begin
            cause_q       <= cause_d;
            illegal_q     <= illegal_d;
            first_valid_q <= first_valid_d;
            first_idx_q   <= first_idx_d;
            count_q       <= count_d;
        end
    end

`ifdef VRC_CAPTURE_EN
    logic [15:0] last_pc_q, last_pc_d;
    logic [15:0] last_addr_q, last_addr_d;

    always_comb begin
        last_pc_d   = episode_start ? pc        : last_pc_q;
        last_addr_d = episode_start ? data_addr : last_addr_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_pc_q   <= '0;
            last_addr_q <= '0;
        end else begin
            last_pc_q   <= last_pc_d;
            last_addr_q <= last_addr_d;
        end
    end

    assign last_pc_rd   = last_pc_q;
    assign last_addr_rd = last_addr_q;
`else
    logic unused_capture;
    assign unused_capture = ^data_addr;
    assign last_pc_rd     = '0;
    assign last_addr_rd   = '0;
`endif

    always_comb begin
        rdata = '0;
        if (rd) begin
            case (reg_idx)
                REG_CAUSE:     rdata = {first_valid_q, 5'b0, first_idx_q, 3'b0, illegal_q, cause_q};
                REG_COUNT:     rdata = count_q;
                REG_LAST_PC:   rdata = last_pc_rd;
                REG_LAST_ADDR: rdata = last_addr_rd;
                default:       rdata = '0;
            endcase
        end
    end

    assign bus.per_dout = rdata;

endmodule

// File: rtl/violation_reset_ctrl.sv
// Violation reset controller top: edge detect, reset-width FSM and counter.
// Define VRC_CAPTURE_EN to latch pc/data_addr at the start of each reset episode.
module violation_reset_ctrl
    import violation_reset_ctrl_pkg::*;
#(
    parameter int          RST_CYCLES = 16,
    parameter logic [15:0] PER_BASE   = 16'h0190,
    parameter logic [15:0] TCB_BASE   = 16'hA000,
    parameter logic [15:0] TCB_SIZE   = 16'h4000
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_VIOL-1:0] viol,
    input  logic [15:0]         pc,
    input  logic [15:0]         data_addr,
    output logic                cpu_rst,
    violation_reset_ctrl_if.slave bus
);

    localparam int               CNT_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RST_CYCLES - 1);

    vrc_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [NUM_VIOL-1:0] viol_q;
    logic [NUM_VIOL-1:0] ev;
    logic                cpu_rst_q, cpu_rst_d;
    logic                episode_start;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_VIOL; gi++) begin : g_edge
            assign ev[gi] = viol[gi] & ~viol_q[gi];
        end
    endgenerate

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        episode_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|ev) begin
                    state_d       = ST_ASSERT;
                    cnt_d         = CNT_LOAD;
                    episode_start = 1'b1;
                end
            end
            ST_ASSERT: begin
                // Later edges only log; levels still high hold reset past the minimum width
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else if (viol == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        cpu_rst_d = (state_d == ST_ASSERT);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            viol_q    <= '0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            viol_q    <= viol;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    assign cpu_rst = cpu_rst_q;

    violation_reset_ctrl_regs #(
        .PER_BASE (PER_BASE),
        .TCB_BASE (TCB_BASE),
        .TCB_SIZE (TCB_SIZE)
    ) u_regs (
        .clk           (clk),
        .reset_n       (reset_n),
        .ev            (ev),
        .episode_start (episode_start),
        .pc            (pc),
        .data_addr     (data_addr),
        .bus           (bus)
    );

endmodule

// File: tb/tb_violation_reset_ctrl.sv
// Directed bench for violation_reset_ctrl: reset width, cause/count logging,
// TCB-gated clears, saturation, async reset and optional capture.
module tb_violation_reset_ctrl;

    localparam logic [13:0] BASE_W = 14'h00C8;
    localparam logic [15:0] PC_TCB = 16'hA100;
    localparam logic [15:0] PC_OUT = 16'h4400;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  viol = 4'b0;
    logic [15:0] pc = PC_TCB;
    logic [15:0] data_addr = 16'h0;
    logic        cpu_rst;

    int n_checks = 0;
    int n_fail = 0;
    int hi_total = 0;
    int base;

    violation_reset_ctrl_if bus_if();

    violation_reset_ctrl dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .viol      (viol),
        .pc        (pc),
        .data_addr (data_addr),
        .cpu_rst   (cpu_rst),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (cpu_rst === 1'b1) hi_total <= hi_total + 1;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end else begin
            $display("ok   %s: %h", tag, obs);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [15:0] din, input logic [1:0] we);
        $display("wr off=%0d din=%h we=%b pc=%h", off, din, we, pc);
        bus_if.per_addr = BASE_W + 14'(off);
        bus_if.per_din  = din;
        bus_if.per_we   = we;
        bus_if.per_en   = 1'b1;
        tick(1);
        bus_if.per_en   = 1'b0;
        bus_if.per_we   = 2'b00;
    endtask

    task automatic check_reg(input string tag, input logic [1:0] off, input logic [15:0] exp);
        logic [15:0] d;
        bus_if.per_addr = BASE_W + 14'(off);
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b1;
        #1;
        d = bus_if.per_dout;
        bus_if.per_en   = 1'b0;
        $display("rd off=%0d data=%h", off, d);
        check_eq(tag, d, exp);
        tick(1);
    endtask

    initial begin
        bus_if.per_addr = '0;
        bus_if.per_din  = '0;
        bus_if.per_we   = 2'b00;
        bus_if.per_en   = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(1);

        // Reset state and idle read data
        check_eq("rst_cpu_rst", 16'(cpu_rst), 16'h0);
        check_reg("rst_cause", 2'd0, 16'h0000);
        check_reg("rst_count", 2'd1, 16'h0000);
        bus_if.per_addr = BASE_W;
        #1;
        check_eq("dout_no_en", bus_if.per_dout, 16'h0000);
        bus_if.per_addr = 14'h0010;
        bus_if.per_en   = 1'b1;
        #1;
        check_eq("dout_unsel", bus_if.per_dout, 16'h0000);
        bus_if.per_en = 1'b0;
        tick(1);

        // 1: uart pulse held three cycles gives exactly the minimum width
        base = hi_total;
        viol = 4'b0001;
        check_eq("t1_pre", 16'(cpu_rst), 16'h0);
        tick(1);
        check_eq("t1_rise", 16'(cpu_rst), 16'h1);
        tick(2);
        viol = 4'b0000;
        tick(25);
        check_eq("t1_width", 16'(hi_total - base), 16'd16);
        check_eq("t1_low", 16'(cpu_rst), 16'h0);
        check_reg("t1_cause", 2'd0, 16'h8001);
        check_reg("t1_count", 2'd1, 16'd1);

        // 2: long irq level extends reset until it drops
        base = hi_total;
        viol = 4'b0100;
        tick(40);
        check_eq("t2_hold", 16'(cpu_rst), 16'h1);
        viol = 4'b0000;
        tick(1);
        check_eq("t2_fall", 16'(cpu_rst), 16'h0);
        check_eq("t2_width", 16'(hi_total - base), 16'd40);
        check_reg("t2_cause", 2'd0, 16'h8005);
        check_reg("t2_count", 2'd1, 16'd2);

        // Clear log from TCB
        pc = PC_TCB;
        bus_write(2'd0, 16'h801F, 2'b11);
        bus_write(2'd1, 16'hFFFF, 2'b11);
        check_reg("clr_cause", 2'd0, 16'h0000);
        check_reg("clr_count", 2'd1, 16'h0000);

        // 3: two bits at once, then a later edge inside the same episode
        base = hi_total;
        viol = 4'b1010;
        tick(2);
        viol = 4'b0000;
        tick(3);
        viol = 4'b0001;
        tick(1);
        viol = 4'b0000;
        tick(25);
        check_eq("t3_width", 16'(hi_total - base), 16'd16);
        check_reg("t3_cause", 2'd0, 16'h810B);
        check_reg("t3_count", 2'd1, 16'd2);

        // 4: writes from outside TCB are ignored and flagged
        pc = PC_OUT;
        bus_write(2'd0, 16'h801F, 2'b11);
        bus_write(2'd1, 16'h0000, 2'b11);
        check_reg("t4_cause_ill", 2'd0, 16'h811B);
        check_reg("t4_count_ill", 2'd1, 16'd2);
        pc = PC_TCB;
        bus_write(2'd0, 16'h0010, 2'b01);
        check_reg("t4_ill_clr", 2'd0, 16'h810B);
        bus_write(2'd0, 16'h801F, 2'b10);
        check_reg("t4_first_clr", 2'd0, 16'h000B);
        bus_write(2'd0, 16'h801F, 2'b11);
        check_reg("t4_cause_clr", 2'd0, 16'h0000);
        bus_write(2'd1, 16'h0000, 2'b10);
        check_reg("t4_count_hi", 2'd1, 16'd2);

        // Same-cycle clear and event: the event wins
        viol = 4'b0001;
        bus_write(2'd1, 16'h0000, 2'b11);
        viol = 4'b0000;
        tick(25);
        check_reg("sim_count", 2'd1, 16'd1);
        check_reg("sim_cause0", 2'd0, 16'h8001);
        viol = 4'b0001;
        bus_write(2'd0, 16'h0001, 2'b01);
        viol = 4'b0000;
        tick(25);
        check_reg("sim_cause1", 2'd0, 16'h8001);
        check_reg("sim_count2", 2'd1, 16'd2);

        // 5: one edge per cycle drives the counter into saturation
        bus_write(2'd1, 16'h0000, 2'b11);
        for (int i = 0; i < 10; i++) begin
            viol = (i % 2 == 1) ? 4'b0010 : 4'b0001;
            tick(1);
        end
        check_reg("t5_count10", 2'd1, 16'd10);
        for (int i = 0; i < 65530; i++) begin
            viol = (i % 2 == 1) ? 4'b0001 : 4'b0010;
            tick(1);
        end
        viol = 4'b0000;
        tick(25);
        check_reg("t5_sat", 2'd1, 16'hFFFF);
        check_eq("t5_idle", 16'(cpu_rst), 16'h0);

        // Async reset in the middle of an episode
        viol = 4'b0001;
        tick(3);
        check_eq("t5_pre_rst", 16'(cpu_rst), 16'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("t5_rst_cpu", 16'(cpu_rst), 16'h0);
        viol = 4'b0000;
        check_reg("t5_rst_cause", 2'd0, 16'h0000);
        check_reg("t5_rst_count", 2'd1, 16'h0000);
        reset_n = 1'b1;
        tick(2);

        // 6: capture at episode start only
        pc = 16'hE010;
        data_addr = 16'h0082;
        viol = 4'b1000;
        tick(1);
        pc = 16'h1234;
        data_addr = 16'h5555;
        viol = 4'b1100;
        tick(1);
        pc = PC_TCB;
        data_addr = 16'h0000;
`ifdef VRC_CAPTURE_EN
        check_reg("t6_last_pc", 2'd2, 16'hE010);
        check_reg("t6_last_addr", 2'd3, 16'h0082);
`else
        check_reg("t6_last_pc", 2'd2, 16'h0000);
        check_reg("t6_last_addr", 2'd3, 16'h0000);
`endif
        viol = 4'b0000;
        tick(25);
        check_reg("t6_cause", 2'd0, 16'h830C);
        check_reg("t6_count", 2'd1, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
